param_mod_counter: RTL
======================

// Module: param_mod_counter
// PURPOSE
//  Parametrised synchronous modulo-N up/down counter; successor to the fixed 3-bit
//  toggle-flop counter. Adds programmable width and modulus, direction control,
//  count enable, synchronous clear/load, terminal-count and wrap flags.
//  Used as a general timebase/sequencer in the assignment designs.
// PARAMETERS
//  WIDTH     4   counter width in bits (>=2)
//  MOD_MAX   9   highest count value; sequence is 0..MOD_MAX (MOD_MAX <= 2**WIDTH-1)
//  SATURATE  0   0 = wrap at the boundary; 1 = hold at the boundary
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      asynchronous, active-high reset
//  clr       in   1      synchronous clear to 0
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  value to load
//  en        in   1      count enable
//  up_dn     in   1      1 = count up, 0 = count down
//  q         out  WIDTH  current count, registered
//  tc        out  1      terminal count, combinational
//  wrap      out  1      one-cycle pulse, registered
//  q_gray    out  WIDTH  Gray-coded count; exists only with PMC_GRAY_OUT_EN
// BEHAVIOUR
//  - Reset (async, active-high) clock clk: q=0, wrap=0, q_gray=0 immediately; held while reset=1.
//  - Priority per rising edge: clr > load > en. With none of them active, q holds.
//  - clr: q<=0 next edge, wrap<=0. Applies regardless of en/load.
//  - load: q<=load_val, or MOD_MAX if load_val>MOD_MAX (clamp). wrap<=0.
//  - en, up_dn=1: q<MOD_MAX -> q+1. q==MOD_MAX -> 0 (SATURATE=0) or hold (SATURATE=1).
//  - en, up_dn=0: q>0 -> q-1. q==0 -> MOD_MAX (SATURATE=0) or hold (SATURATE=1).
//  - Arithmetic is WIDTH bits. Wrap comes from compare against MOD_MAX, never from
//    natural overflow. q must never exceed MOD_MAX.
//  - tc = en & ((up_dn & q==MOD_MAX) | (~up_dn & q==0)). Combinational, zero latency.
//    tc asserts in SATURATE mode too.
//  - wrap: registered. Asserted for exactly one cycle following an edge where a
//    boundary wrap occurred (SATURATE=0 only). Always 0 when SATURATE=1.
//  - Direction change mid-count takes effect on the same edge. No state beyond q.
//  - Latency: 1 clk from en/clr/load to q.
//  - Reset asserted mid-count: q=0 asynchronously. First count after reset release
//    goes 0->1 (up) or 0->MOD_MAX (down).
// CONFIGURATION
//  PMC_GRAY_OUT_EN defined:
//   - q_gray port present. q_gray = next_q ^ (next_q>>1), registered on the same edge as q.
//   - q_gray is always coherent with q; same reset and clr behaviour.
//   - Gray codes are for binary values. Across a modulo wrap, more than one bit may change.
//  PMC_GRAY_OUT_EN undefined: q_gray port and register absent. All other behaviour identical.
// TESTING (WIDTH=4, MOD_MAX=9 unless noted)
//  1. reset=1 mid-count at q=5 -> q=0, wrap=0 before next edge. Release, en=1, up -> q=1.
//  2. en=1 up_dn=1, 12 edges from 0 -> q: 1..9,0,1,2. tc=1 while q=9.
//     wrap=1 only in the cycle after 9->0.
//  3. en=1 up_dn=0 from 0 -> q=9,8,7. tc=1 at q=0. wrap pulses once after 0->9.
//  4. load=1 load_val=13 -> q=9. load=1 clr=1 same edge -> q=0. load=1 en=1 load_val=4 -> q=4.
//  5. SATURATE=1: up from 8 -> 9,9,9, wrap=0, tc=1. down from 1 -> 0,0.
//  6. PMC_GRAY_OUT_EN: count 0..9 up -> q_gray 0,1,3,2,6,7,5,4,C,D, matching q every cycle.

Source files
------------

// File: rtl/param_mod_counter.sv
// param_mod_counter: modulo-N up/down counter with clear, clamped load, terminal-count and wrap flags.
// Optional registered Gray-coded output when PMC_GRAY_OUT_EN is defined.
module param_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MOD_MAX  = 9,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
`ifdef PMC_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MOD_MAX);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d, up_nxt, dn_nxt, ld_val;
    logic             wrap_q, wrap_d, at_max, at_zero;

    always_comb begin
        at_max  = cnt_q == MAX;
        at_zero = cnt_q == ZERO;
        tc      = en & ((up_dn & at_max) | (~up_dn & at_zero));
        // Boundary handling is by compare against MAX so q never leaves 0..MAX.
        up_nxt  = at_max ? (SATURATE ? cnt_q : ZERO) : cnt_q + ONE;
        dn_nxt  = at_zero ? (SATURATE ? cnt_q : MAX) : cnt_q - ONE;
        ld_val  = (load_val > MAX) ? MAX : load_val;
        cnt_d   = clr ? ZERO : load ? ld_val : en ? (up_dn ? up_nxt : dn_nxt) : cnt_q;
        wrap_d  = ~clr & ~load & tc & ~SATURATE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;

`ifdef PMC_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_q, gray_d;

    // Encoded from cnt_d so the Gray register lands on the same edge as q.
    always_comb gray_d = cnt_d ^ (cnt_d >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) gray_q <= '0;
        else       gray_q <= gray_d;
    end

    assign q_gray = gray_q;
`endif
endmodule
